// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, TCFG field positions and ESTAT.IS bit indices
package csr_pkg;
  localparam logic [13:0] CSR_ECTL      = 14'h004;
  localparam logic [13:0] CSR_ESTAT     = 14'h005;
  localparam logic [13:0] CSR_TCFG      = 14'h041;
  localparam logic [13:0] CSR_TVAL      = 14'h042;
  localparam logic [13:0] CSR_CNTC      = 14'h043;
  localparam logic [13:0] CSR_TICLR     = 14'h044;
  localparam logic [13:0] CSR_TIPEND    = 14'h1BF;
  localparam logic [13:0] CSR_CHAN_BASE = 14'h1C0;
  localparam int CHAN_STRIDE = 4;
  localparam int TCFG_EN = 0;
  localparam int TCFG_PERIODIC = 1;
  localparam int TCFG_INITVAL_LO = 2;
  localparam int IS_SWI_LO = 0;
  localparam int IS_HWI_LO = 2;
  localparam int IS_TI = 11;
  localparam int IS_IPI = 12;
  localparam int IS_W = 13;
  localparam int LIE_RSVD = 10;
  typedef enum logic [1:0] {CH_TCFG = 2'd0, CH_TVAL = 2'd1, CH_TICLR = 2'd2} chan_reg_e;
  // Channel 0 sits at the architectural addresses; the rest are packed from CHAN_BASE.
  function automatic logic [13:0] chan_addr(input int k, input chan_reg_e r);
    logic [13:0] arch;
    arch = r == CH_TCFG ? CSR_TCFG : r == CH_TVAL ? CSR_TVAL : CSR_TICLR;
    return k == 0 ? arch : CSR_CHAN_BASE + 14'(CHAN_STRIDE * (k - 1)) + 14'(r);
  endfunction
endpackage

// File: rtl/csr_timer_chan.sv
// csr_timer_chan: one countdown timer channel with TCFG, TVAL and a pending flag
module csr_timer_chan import csr_pkg::*; #(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic               clr_we,
  input  logic [TIMER_W-1:0] wr_data,
  output logic [TIMER_W-1:0] tcfg,
  output logic [TIMER_W-1:0] tval,
  output logic               pending
);
  logic [TIMER_W-1:0] tcfg_q, tcfg_d, tval_q, tval_d, reload;
  logic pending_q, pending_d, en, periodic, expire;
  always_comb begin
    en = tcfg_q[TCFG_EN];
    periodic = tcfg_q[TCFG_PERIODIC];
    reload = {tcfg_q[TIMER_W-1:TCFG_INITVAL_LO], 2'b00};
    expire = en && tval_q == '0 && !cfg_we;
    tcfg_d = cfg_we ? wr_data : tcfg_q;
    if (expire && !periodic) tcfg_d[TCFG_EN] = 1'b0;
    tval_d = cfg_we ? {wr_data[TIMER_W-1:TCFG_INITVAL_LO], 2'b00} :
             !en ? tval_q :
             tval_q != '0 ? tval_q - TIMER_W'(1) :
             periodic ? reload : '1;
    // expiry beats a same-cycle clear so no event is dropped
    pending_d = expire || (pending_q && !clr_we);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg_q <= '0;
      tval_q <= '1;
      pending_q <= 1'b0;
    end else begin
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
      pending_q <= pending_d;
    end
  end
  assign tcfg = tcfg_q;
  assign tval = tval_q;
  assign pending = pending_q;
endmodule

// File: rtl/csr_timer_intc.sv
// csr_timer_intc: ESTAT.IS/ECTL.LIE, timer channels, TIPEND and stable counter for the CSR file
module csr_timer_intc import csr_pkg::*; #(
  parameter int NUM_TIMERS = 2,
  parameter int TIMER_W = 32,
  parameter int HWI_NUM = 8,
  parameter int CNT_W = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [13:0]        rd_addr,
  output logic [31:0]        rd_data,
  output logic               rd_hit,
  input  logic               csr_wr_en,
  input  logic [13:0]        wr_addr,
  input  logic [31:0]        wr_data,
  input  logic               crmd_ie,
  input  logic [HWI_NUM-1:0] hw_int,
  output logic               has_int,
  output logic [CNT_W-1:0]   stable_cnt
);
  logic [1:0] swi_q, swi_d;
  logic [HWI_NUM-1:0] hwi_q, hwi_d;
  logic [IS_W-1:0] lie_q, lie_d, is_vec;
  logic [31:0] cntc_q, cntc_d;
  logic [CNT_W-1:0] raw_q, raw_d;
  logic [NUM_TIMERS-1:0] cfg_we, clr_we, tipend;
  logic [TIMER_W-1:0] tcfg [NUM_TIMERS];
  logic [TIMER_W-1:0] tval [NUM_TIMERS];
  for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_chan
    assign cfg_we[k] = csr_wr_en && wr_addr == chan_addr(k, CH_TCFG);
    assign clr_we[k] = csr_wr_en && wr_addr == chan_addr(k, CH_TICLR) && wr_data[0];
    csr_timer_chan #(.TIMER_W(TIMER_W)) u_chan (
      .clk(clk),
      .reset(reset),
      .cfg_we(cfg_we[k]),
      .clr_we(clr_we[k]),
      .wr_data(wr_data[TIMER_W-1:0]),
      .tcfg(tcfg[k]),
      .tval(tval[k]),
      .pending(tipend[k])
    );
  end
  always_comb begin
    swi_d = csr_wr_en && wr_addr == CSR_ESTAT ? wr_data[1:0] : swi_q;
    hwi_d = hw_int;
    lie_d = csr_wr_en && wr_addr == CSR_ECTL ? wr_data[IS_W-1:0] & ~(IS_W'(1) << LIE_RSVD) : lie_q;
    cntc_d = csr_wr_en && wr_addr == CSR_CNTC ? wr_data : cntc_q;
    raw_d = raw_q + CNT_W'(1);
    is_vec = '0;
    is_vec[IS_SWI_LO +: 2] = swi_q;
    is_vec[IS_HWI_LO +: HWI_NUM] = hwi_q;
    is_vec[IS_TI] = |tipend;
    is_vec[IS_IPI] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      swi_q <= '0;
      hwi_q <= '0;
      lie_q <= '0;
      cntc_q <= '0;
      raw_q <= '0;
    end else begin
      swi_q <= swi_d;
      hwi_q <= hwi_d;
      lie_q <= lie_d;
      cntc_q <= cntc_d;
      raw_q <= raw_d;
    end
  end
  assign has_int = crmd_ie && |(is_vec & lie_q);
  assign stable_cnt = raw_q + CNT_W'($signed(cntc_q));
  always_comb begin
    rd_hit = 1'b1;
    rd_data = '0;
    if (rd_addr == CSR_ESTAT) rd_data = 32'(is_vec);
    else if (rd_addr == CSR_ECTL) rd_data = 32'(lie_q);
    else if (rd_addr == CSR_CNTC) rd_data = cntc_q;
    else if (rd_addr == CSR_TIPEND) rd_data = 32'(tipend);
    else rd_hit = 1'b0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (rd_addr == chan_addr(i, CH_TCFG)) begin
        rd_hit = 1'b1;
        rd_data = 32'(tcfg[i]);
      end
      if (rd_addr == chan_addr(i, CH_TVAL)) begin
        rd_hit = 1'b1;
        rd_data = 32'(tval[i]);
      end
      if (rd_addr == chan_addr(i, CH_TICLR)) rd_hit = 1'b1;
    end
  end
endmodule

// File: tb/tb_csr_timer_intc.sv
// tb_csr_timer_intc: directed and random stimulus checked against a behavioural model of the timer/intc CSRs
module tb_csr_timer_intc;
  logic clk = 1'b0, reset, csr_wr_en, crmd_ie, rd_hit, has_int;
  logic [13:0] rd_addr, wr_addr;
  logic [31:0] wr_data, rd_data;
  logic [7:0] hw_int;
  logic [63:0] stable_cnt;
  int checks = 0, passed = 0, fails = 0;
  always #50 clk = ~clk;
  csr_timer_intc dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_hit(rd_hit),
    .csr_wr_en(csr_wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .crmd_ie(crmd_ie),
    .hw_int(hw_int), .has_int(has_int), .stable_cnt(stable_cnt)
  );
  logic [63:0] m_raw;
  logic [31:0] m_cntc;
  logic [1:0] m_swi;
  logic [7:0] m_hwi;
  logic [12:0] m_lie;
  logic m_en [2], m_per [2], m_pend [2];
  logic [29:0] m_init [2];
  logic [31:0] m_tval [2];
  logic [13:0] rd_list [14] = '{14'h005, 14'h004, 14'h043, 14'h1BF, 14'h041, 14'h042, 14'h044,
                                14'h1C0, 14'h1C1, 14'h1C2, 14'h000, 14'h045, 14'h1C4, 14'h1BE};
  logic [13:0] wr_list [10] = '{14'h005, 14'h004, 14'h043, 14'h1BF, 14'h041, 14'h042, 14'h044,
                                14'h1C0, 14'h1C1, 14'h1C2};
  function automatic logic [13:0] tcfg_a(int k); return k == 0 ? 14'h041 : 14'h1C0; endfunction
  function automatic logic [13:0] tval_a(int k); return k == 0 ? 14'h042 : 14'h1C1; endfunction
  function automatic logic [13:0] ticlr_a(int k); return k == 0 ? 14'h044 : 14'h1C2; endfunction
  function automatic logic [12:0] m_is();
    return {1'b0, m_pend[0] | m_pend[1], 1'b0, m_hwi, m_swi};
  endfunction
  function automatic logic [32:0] m_read(logic [13:0] a);
    logic [32:0] r;
    r = '0;
    if (a == 14'h005) r = {1'b1, 19'b0, m_is()};
    if (a == 14'h004) r = {1'b1, 19'b0, m_lie};
    if (a == 14'h043) r = {1'b1, m_cntc};
    if (a == 14'h1BF) r = {1'b1, 30'b0, m_pend[1], m_pend[0]};
    for (int k = 0; k < 2; k++) begin
      if (a == tcfg_a(k)) r = {1'b1, m_init[k], m_per[k], m_en[k]};
      if (a == tval_a(k)) r = {1'b1, m_tval[k]};
      if (a == ticlr_a(k)) r = {1'b1, 32'b0};
    end
    return r;
  endfunction
  task automatic model_step();
    if (reset) begin
      m_raw = '0; m_cntc = '0; m_swi = '0; m_hwi = '0; m_lie = '0;
      for (int k = 0; k < 2; k++) begin
        m_en[k] = 0; m_per[k] = 0; m_pend[k] = 0; m_init[k] = '0; m_tval[k] = '1;
      end
    end else begin
      m_raw = m_raw + 1;
      m_hwi = hw_int;
      if (csr_wr_en && wr_addr == 14'h005) m_swi = wr_data[1:0];
      if (csr_wr_en && wr_addr == 14'h004) m_lie = wr_data[12:0] & 13'h1BFF;
      if (csr_wr_en && wr_addr == 14'h043) m_cntc = wr_data;
      for (int k = 0; k < 2; k++) begin
        if (csr_wr_en && wr_addr == ticlr_a(k) && wr_data[0]) m_pend[k] = 0;
        if (csr_wr_en && wr_addr == tcfg_a(k)) begin
          m_en[k] = wr_data[0]; m_per[k] = wr_data[1]; m_init[k] = wr_data[31:2];
          m_tval[k] = {wr_data[31:2], 2'b00};
        end else if (m_en[k]) begin
          if (m_tval[k] != 0) m_tval[k] = m_tval[k] - 1;
          else begin
            m_pend[k] = 1;
            if (m_per[k]) m_tval[k] = {m_init[k], 2'b00};
            else begin m_tval[k] = '1; m_en[k] = 0; end
          end
        end
      end
    end
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    logic [32:0] e;
    foreach (rd_list[i]) begin
      rd_addr = rd_list[i];
      #1;
      e = m_read(rd_list[i]);
      chk($sformatf("rd_data@%h", rd_list[i]), {32'b0, rd_data}, {32'b0, e[31:0]});
      chk($sformatf("rd_hit@%h", rd_list[i]), {63'b0, rd_hit}, {63'b0, e[32]});
    end
    chk("has_int", {63'b0, has_int}, {63'b0, crmd_ie & |(m_is() & m_lie)});
    chk("stable_cnt", stable_cnt, m_raw + {{32{m_cntc[31]}}, m_cntc});
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask
  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    csr_wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    csr_wr_en = 0;
  endtask
  task automatic expect_rd(input string tag, input logic [13:0] a, input logic [31:0] e);
    rd_addr = a;
    #1;
    chk(tag, {32'b0, rd_data}, {32'b0, e});
  endtask
  initial begin
    int n;
    reset = 1; csr_wr_en = 0; wr_addr = '0; wr_data = '0; rd_addr = '0; crmd_ie = 0; hw_int = '0;
    @(negedge clk);
    tick(); tick();
    expect_rd("tval0_rst", 14'h042, 32'hFFFF_FFFF);
    expect_rd("tipend_rst", 14'h1BF, 32'h0);
    chk("cnt_rst", stable_cnt, 64'h0);
    reset = 0;
    // one-shot channel 0
    wr(14'h041, 32'h11);
    expect_rd("tval0_load", 14'h042, 32'h10);
    repeat (16) tick();
    expect_rd("tval0_zero", 14'h042, 32'h0);
    expect_rd("tipend_before", 14'h1BF, 32'h0);
    tick();
    expect_rd("tipend_expire", 14'h1BF, 32'h1);
    expect_rd("tval0_idle", 14'h042, 32'hFFFF_FFFF);
    expect_rd("tcfg0_en_clr", 14'h041, 32'h10);
    expect_rd("estat_ti", 14'h005, 32'h800);
    crmd_ie = 1;
    wr(14'h004, 32'h800);
    chk("has_int_ti", {63'b0, has_int}, 64'h1);
    wr(14'h044, 32'h1);
    chk("has_int_clr", {63'b0, has_int}, 64'h0);
    // periodic channel 1
    wr(14'h1C0, 32'h0B);
    repeat (8) tick();
    expect_rd("tipend1_wait", 14'h1BF, 32'h0);
    tick();
    expect_rd("tipend1_set", 14'h1BF, 32'h2);
    repeat (8) tick();
    wr(14'h1C2, 32'h1);
    expect_rd("tipend1_set_wins", 14'h1BF, 32'h2);
    wr(14'h1C2, 32'h1);
    expect_rd("tipend1_clr", 14'h1BF, 32'h0);
    // independence
    wr(14'h041, 32'h0F);
    n = 0;
    while (!(m_pend[0] && m_pend[1] && m_tval[1] != 0) && n < 60) begin tick(); n++; end
    chk("wait_both", {63'b0, m_pend[0] && m_pend[1]}, 64'h1);
    wr(14'h1C2, 32'h1);
    expect_rd("tipend_only0", 14'h1BF, 32'h1);
    n = 0;
    while (!(m_tval[0] == 0 && !m_pend[0]) && n < 60) begin
      if (m_pend[0]) wr(14'h044, 32'h1); else tick();
      n++;
    end
    chk("wait_ch0_zero", {63'b0, m_tval[0] == 0 && !m_pend[0]}, 64'h1);
    wr(14'h041, 32'h9);
    rd_addr = 14'h1BF; #1;
    chk("tcfg_beats_expiry", {63'b0, rd_data[0]}, 64'h0);
    expect_rd("tval0_reload_new", 14'h042, 32'h8);
    wr(14'h041, 32'h0);
    wr(14'h1C0, 32'h0);
    wr(14'h044, 32'h1);
    wr(14'h1C2, 32'h1);
    // hardware interrupt line
    wr(14'h004, 32'h10);
    crmd_ie = 0; hw_int = 8'h04;
    tick();
    rd_addr = 14'h005; #1;
    chk("is4_set", {63'b0, rd_data[4]}, 64'h1);
    chk("has_int_ie0", {63'b0, has_int}, 64'h0);
    crmd_ie = 1; #1;
    chk("has_int_ie1", {63'b0, has_int}, 64'h1);
    hw_int = 8'h00;
    tick();
    rd_addr = 14'h005; #1;
    chk("is4_clr", {63'b0, rd_data[4]}, 64'h0);
    // ESTAT / ECTL write masks
    wr(14'h005, 32'hFFFF_FFFF);
    rd_addr = 14'h005; #1;
    chk("estat_hi_zero", {45'b0, rd_data[31:13]}, 64'h0);
    chk("estat_swi", {62'b0, rd_data[1:0]}, 64'h3);
    wr(14'h004, 32'h1FFF);
    expect_rd("ectl_mask", 14'h004, 32'h1BFF);
    wr(14'h005, 32'h0);
    // counter offset and reset mid-count
    wr(14'h043, 32'hFFFF_FFFF);
    chk("cnt_minus1", stable_cnt, m_raw - 64'h1);
    wr(14'h041, 32'h11);
    repeat (5) tick();
    reset = 1;
    tick();
    reset = 0;
    expect_rd("tval0_midrst", 14'h042, 32'hFFFF_FFFF);
    expect_rd("tipend_midrst", 14'h1BF, 32'h0);
    chk("cnt_midrst", stable_cnt, 64'h0);
    chk("has_int_midrst", {63'b0, has_int}, 64'h0);
    // random phase
    for (int c = 0; c < 600; c++) begin
      reset = $urandom_range(0, 149) == 0;
      csr_wr_en = $urandom_range(0, 2) == 0;
      wr_addr = $urandom_range(0, 7) == 0 ? 14'($urandom) : wr_list[$urandom_range(0, 9)];
      wr_data = $urandom_range(0, 1) ? $urandom : ($urandom & 32'h3F);
      crmd_ie = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) hw_int = 8'($urandom);
      tick();
    end
    reset = 0; csr_wr_en = 0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
